alu_result_drain: RTL

ALU_RESULT_DRAIN -- requirements
Module: alu_result_drain

---
 rtl/alu_result_drain_pkg.sv | 10 +
 rtl/alu_result_fifo.sv | 45 ++++
 rtl/alu_result_drain.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_result_drain_pkg.sv
// Shared constants for the ALU result drain: FSM encoding and drop counter width.
package alu_result_drain_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/alu_result_fifo.sv
// Result storage for the drain: circular buffer with a level counter.
// Storage cells are not reset; the pointers and level make stale data unreachable.
module alu_result_fifo #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_result_drain.sv
// Buffers double-width ALU results and drains each as two WIDTH-bit beats
// (low half, then high half with carry), tracking dropped results when full.
module alu_result_drain
  import alu_result_drain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     res_valid,
  input  logic [2*WIDTH-1:0]       res_data,
  input  logic                     res_carry,
  input  logic                     out_ready,
  input  logic                     clr_err,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow_err,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]         FULL_LEVEL = LW'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX   = '1;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [2*WIDTH:0]   head;
  logic               push;
  logic               pop;
  logic               drop;
  logic [LW-1:0]      level_after;

  assign pop         = (state == ST_HIGH) && out_ready;
  assign push        = res_valid && ((fill_level != FULL_LEVEL) || pop);
  assign drop        = res_valid && !push;
  assign level_after = fill_level + LW'(push) - LW'(pop);

  alu_result_fifo #(
    .DATA_W (2*WIDTH+1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   ({res_carry, res_data}),
    .rdata   (head),
    .level   (fill_level)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (level_after != '0) state_next = ST_LOW;
      ST_LOW:  if (out_ready) state_next = ST_HIGH;
      ST_HIGH: if (out_ready) state_next = (level_after != '0) ? ST_LOW : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Outputs decode from state alone, so they hold steady while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_carry = 1'b0;
    case (state)
      ST_LOW: begin
        out_valid = 1'b1;
        out_data  = head[WIDTH-1:0];
      end
      ST_HIGH: begin
        out_valid = 1'b1;
        out_data  = head[2*WIDTH-1:WIDTH];
        out_last  = 1'b1;
        out_carry = head[2*WIDTH];
      end
      default: ;
    endcase
  end

  // A clear on the same edge as a drop leaves exactly that one drop recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
      drop_cnt     <= '0;
    end else if (clr_err) begin
      overflow_err <= drop;
      drop_cnt     <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow_err <= 1'b1;
      if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
